// File: rtl/bit_unstuffer.sv
// bit_unstuffer: drops the stuffed 0 that follows MAX_ONES consecutive 1s,
// flags a stuff violation when that bit is a 1 instead, and packs the kept
// bits LSB-first into bytes for the downstream packet decoder and CRC checker.
module bit_unstuffer #(
  parameter int MAX_ONES = 6
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       bstr_in,
  input  logic       bstr_in_ready,
  input  logic       pkt_end,
  output logic       bstr_out,
  output logic       bstr_out_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       stuff_err,
  output logic       align_err,
  output logic       pkt_done
);

  localparam logic [2:0] MAX_C = 3'(MAX_ONES);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_e;

  state_e     state_q, state_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] byte_q, byte_d;
  logic       bout_q, bout_d;
  logic       brdy_q, brdy_d;
  logic       bvld_q, bvld_d;
  logic       serr_q, serr_d;
  logic       aerr_q, aerr_d;
  logic       pdone_q, pdone_d;

  // Next-state and registered-output logic; pkt_end wins over an input bit.
  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    bout_d  = bout_q;
    serr_d  = serr_q;
    brdy_d  = 1'b0;
    bvld_d  = 1'b0;
    aerr_d  = 1'b0;
    pdone_d = 1'b0;
    if (pkt_end) begin
      pdone_d = 1'b1;
      aerr_d  = (state_q == ACTIVE) && (idx_q != 3'd0);
      ones_d  = 3'd0;
      idx_d   = 3'd0;
      shreg_d = 8'h00;
      serr_d  = 1'b0;
      state_d = IDLE;
    end else if (bstr_in_ready && state_q != ERROR) begin
      if (ones_q == MAX_C) begin
        // Stuffed position: the bit is never forwarded either way.
        ones_d = 3'd0;
        if (bstr_in) begin
          serr_d  = 1'b1;
          state_d = ERROR;
        end else begin
          state_d = ACTIVE;
        end
      end else begin
        state_d = ACTIVE;
        bout_d  = bstr_in;
        brdy_d  = 1'b1;
        shreg_d = {bstr_in, shreg_q[7:1]};
        ones_d  = bstr_in ? 3'(ones_q + 3'd1) : 3'd0;
        idx_d   = 3'(idx_q + 3'd1);
        if (idx_q == 3'd7) begin
          byte_d = {bstr_in, shreg_q[7:1]};
          bvld_d = 1'b1;
        end
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      ones_q  <= 3'd0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      byte_q  <= 8'h00;
      bout_q  <= 1'b0;
      brdy_q  <= 1'b0;
      bvld_q  <= 1'b0;
      serr_q  <= 1'b0;
      aerr_q  <= 1'b0;
      pdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      byte_q  <= byte_d;
      bout_q  <= bout_d;
      brdy_q  <= brdy_d;
      bvld_q  <= bvld_d;
      serr_q  <= serr_d;
      aerr_q  <= aerr_d;
      pdone_q <= pdone_d;
    end
  end

  assign bstr_out       = bout_q;
  assign bstr_out_ready = brdy_q;
  assign byte_out       = byte_q;
  assign byte_valid     = bvld_q;
  assign stuff_err      = serr_q;
  assign align_err      = aerr_q;
  assign pkt_done       = pdone_q;

endmodule

// File: tb/tb_bit_unstuffer.sv
// Scoreboard bench for bit_unstuffer: a packet-level reference model queues
// timestamped expected events, and a negedge monitor compares every cycle.
module tb_bit_unstuffer;
  localparam int MAXO = 6;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       bstr_in = 1'b0, bstr_in_ready = 1'b0, pkt_end = 1'b0;
  logic       bstr_out, bstr_out_ready, byte_valid, stuff_err, align_err, pkt_done;
  logic [7:0] byte_out;

  bit_unstuffer #(.MAX_ONES(MAXO)) dut (
    .clk(clk), .rst_b(rst_b), .bstr_in(bstr_in), .bstr_in_ready(bstr_in_ready),
    .pkt_end(pkt_end), .bstr_out(bstr_out), .bstr_out_ready(bstr_out_ready),
    .byte_out(byte_out), .byte_valid(byte_valid), .stuff_err(stuff_err),
    .align_err(align_err), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [7:0] v; } ev_t;
  ev_t qbit[$], qbyte[$], qpkt[$], qse[$];

  int nvec = 0, nerr = 0;
  int pcyc = 0, ncyc = 0;
  logic [7:0] exp_hold = 8'h00;
  logic       exp_se = 1'b0;

  // Reference model state: packet-level view of the stream.
  int   run = 0, kept = 0;
  bit   bad = 0;
  logic cur[$];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, ncyc, got, exp);
    end
  endtask

  task automatic model_clear();
    qbit.delete(); qbyte.delete(); qpkt.delete(); qse.delete(); cur.delete();
    run = 0; kept = 0; bad = 0; exp_hold = 8'h00; exp_se = 1'b0;
  endtask

  // Output of the bit sampled at the next edge is visible at negedge t.
  task automatic model_step(input logic v, input logic b, input logic e, input int t);
    logic [7:0] by;
    if (e) begin
      qpkt.push_back('{t, {7'd0, (!bad && (kept % 8) != 0)}});
      if (bad) qse.push_back('{t, 8'h00});
      run = 0; kept = 0; bad = 0; cur.delete();
    end else if (v && !bad) begin
      if (run == MAXO) begin
        run = 0;
        if (b) begin
          bad = 1;
          qse.push_back('{t, 8'h01});
        end
      end else begin
        qbit.push_back('{t, {7'd0, b}});
        cur.push_back(b);
        kept++;
        run = b ? run + 1 : 0;
        if (cur.size() == 8) begin
          for (int i = 0; i < 8; i++) by[i] = cur[i];
          qbyte.push_back('{t, by});
          cur.delete();
        end
      end
    end
  endtask

  always @(posedge clk) pcyc <= pcyc + 1;

  // Monitor: every cycle each output must match the event due now (or idle).
  always @(negedge clk) begin
    ev_t e;
    ncyc = ncyc + 1;
    if (rst_b) begin
      if (qbit.size() > 0 && qbit[0].cyc == ncyc) begin
        e = qbit.pop_front();
        chk("bstr_out_ready", {7'd0, bstr_out_ready}, 8'd1);
        chk("bstr_out", {7'd0, bstr_out}, e.v);
      end else chk("bstr_out_ready_idle", {7'd0, bstr_out_ready}, 8'd0);
      if (qbyte.size() > 0 && qbyte[0].cyc == ncyc) begin
        e = qbyte.pop_front();
        exp_hold = e.v;
        chk("byte_valid", {7'd0, byte_valid}, 8'd1);
      end else chk("byte_valid_idle", {7'd0, byte_valid}, 8'd0);
      chk("byte_out", byte_out, exp_hold);
      if (qpkt.size() > 0 && qpkt[0].cyc == ncyc) begin
        e = qpkt.pop_front();
        chk("pkt_done", {7'd0, pkt_done}, 8'd1);
        chk("align_err", {7'd0, align_err}, e.v);
      end else begin
        chk("pkt_done_idle", {7'd0, pkt_done}, 8'd0);
        chk("align_err_idle", {7'd0, align_err}, 8'd0);
      end
      if (qse.size() > 0 && qse[0].cyc == ncyc) begin
        e = qse.pop_front();
        exp_se = e.v[0];
      end
      chk("stuff_err", {7'd0, stuff_err}, {7'd0, exp_se});
    end
  end

  task automatic drive(input logic v, input logic b, input logic e);
    @(posedge clk); #1;
    bstr_in_ready = v; bstr_in = b; pkt_end = e;
    model_step(v, b, e, pcyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [31:0] bits, input int n, input int gap);
    logic [31:0] w;
    w = bits;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, w[i], 1'b0);
      idle(gap);
    end
  endtask

  task automatic eop();
    drive(1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bstr_out"}, {7'd0, bstr_out}, 8'd0);
    chk({tag, "_bstr_out_ready"}, {7'd0, bstr_out_ready}, 8'd0);
    chk({tag, "_byte_out"}, byte_out, 8'd0);
    chk({tag, "_byte_valid"}, {7'd0, byte_valid}, 8'd0);
    chk({tag, "_stuff_err"}, {7'd0, stuff_err}, 8'd0);
    chk({tag, "_align_err"}, {7'd0, align_err}, 8'd0);
    chk({tag, "_pkt_done"}, {7'd0, pkt_done}, 8'd0);
  endtask

  task automatic mid_reset();
    @(posedge clk); #1;
    bstr_in_ready = 1'b0; bstr_in = 1'b0; pkt_end = 1'b0;
    @(negedge clk); #1;
    rst_b = 1'b0;
    #1 chk_all_zero("async_reset");
    model_clear();
    repeat (2) @(negedge clk);
    #1 rst_b = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("por");
    #1 rst_b = 1'b1;
    idle(2);

    // Byte to 0xFF then 5 bits, asynchronous reset mid-byte, then 0xA5.
    send(32'h0000_00FF, 8, 0);
    eop();
    send(32'h0000_0015, 5, 0);
    mid_reset();
    idle(2);
    send(32'h0000_00A5, 8, 0);
    eop();

    // Stuffed 0 after six 1s is dropped: 1,1,1,1,1,1,0,1,1.
    send(32'b1_1011_1111, 9, 0);
    eop();

    // Seven 1s is a violation; following bits ignored until pkt_end.
    send(32'h0000_007F, 7, 0);
    send(32'h0000_0000, 8, 0);
    eop();

    // 12 kept bits then pkt_end: one byte and an alignment error.
    send(32'h0000_05C3, 12, 0);
    eop();

    // pkt_end coincides with the 8th bit, then a fresh six-1s-then-0 packet.
    send(32'h0000_003F, 7, 0);
    drive(1'b1, 1'b1, 1'b1);
    idle(1);
    send(32'h0000_003F, 7, 0);
    send(32'h0000_0001, 1, 0);
    eop();

    // Gapped delivery of 0x7E.
    send(32'h0000_007E, 8, 3);
    eop();

    // Randomized packets: 1-heavy bits, gaps, stray pkt_end, rare resets.
    for (int p = 0; p < 60; p++) begin
      int len;
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        drive(1'b1, ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, 1'b0);
      end
      if ($urandom_range(0, 19) == 0) mid_reset();
      else drive($urandom_range(0, 1) == 1 ? 1'b1 : 1'b0,
                 $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 1'b1);
      idle($urandom_range(0, 2));
    end
    eop();
    idle(3);

    chk("drain_bits", 8'(qbit.size()), 8'd0);
    chk("drain_bytes", 8'(qbyte.size()), 8'd0);
    chk("drain_pkts", 8'(qpkt.size()), 8'd0);
    chk("drain_stuff", 8'(qse.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
